operand_collector: RTL and testbench

- Parametrised successor to the three-slot put accumulator.
- Collects up to DEPTH words of WIDTH bits through a valid/ready put port into internal slots, in arrival order.
- On a flush request it publishes the whole slot set, slot mask and count to held output registers, pulses done and clears the internal slots.
- Sits between the decode/put stage and downstream consumers that need several operands captured as one group.

---
 rtl/operand_collector.sv | 131 +++++++++++++
 tb/tb_operand_collector.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/operand_collector.sv
// operand_collector: gathers up to DEPTH put words into ordered slots and,
// on flush, publishes them as one group to held output registers.
module operand_collector #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned OVF_MODE = 0,
  parameter int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   put_valid,
  input  logic [WIDTH-1:0]       put_data,
  output logic                   put_ready,
  input  logic                   flush,
  output logic [DEPTH*WIDTH-1:0] out_data,
  output logic [DEPTH-1:0]       out_mask,
  output logic [CW-1:0]          out_count,
  output logic [CW-1:0]          count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_FILLING = 2'd1,
    S_FULL    = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0]   slots_q, slots_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [DEPTH*WIDTH-1:0]        out_data_q, out_data_d;
  logic [DEPTH-1:0]              out_mask_q, out_mask_d;
  logic [CW-1:0]                 out_count_q, out_count_d;
  logic                          overflow_q, overflow_d;
  logic                          done_q, done_d;
  logic                          ovf_evt;

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_EMPTY;
      slots_q     <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_count_q <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slots_q     <= slots_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_count_q <= out_count_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  // Put handling first, then flush publishes the post-put slot image.
  always_comb begin
    slots_d     = slots_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_count_d = out_count_q;
    done_d      = 1'b0;
    ovf_evt     = 1'b0;

    if (put_valid) begin
      if (state_q == S_FULL) begin
        ovf_evt = 1'b1;
        if (OVF_MODE == 0) begin
          slots_d[DEPTH-1] = put_data;
        end
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CW'(i) == count_q) begin
            slots_d[i] = put_data;
          end
        end
        count_d = count_q + CW'(1);
      end
    end

    if (ovf_evt) begin
      overflow_d = 1'b1;
    end

    if (flush) begin
      out_data_d = slots_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        out_mask_d[i] = (CW'(i) < count_d);
      end
      out_count_d = count_d;
      slots_d     = '0;
      count_d     = '0;
      // An overflow in the flush cycle itself survives into the next group.
      overflow_d  = ovf_evt;
      done_d      = 1'b1;
    end
  end

  // Next state follows the resulting occupancy.
  always_comb begin
    state_d = state_q;
    if (count_d == '0) begin
      state_d = S_EMPTY;
    end else if (count_d == CW'(DEPTH)) begin
      state_d = S_FULL;
    end else begin
      state_d = S_FILLING;
    end
  end

  assign put_ready = (OVF_MODE == 0) ? 1'b1 : (state_q != S_FULL);
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign out_count = out_count_q;
  assign count     = count_q;
  assign empty     = (state_q == S_EMPTY);
  assign full      = (state_q == S_FULL);
  assign overflow  = overflow_q;
  assign done      = done_q;

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector: one overwrite-mode and one
// reject-mode instance driven by the same stimulus.
module tb_operand_collector;

  logic        clk;
  logic        reset;
  logic        put_valid;
  logic [7:0]  put_data;
  logic        flush;

  logic        rdy0, rdy1;
  logic [23:0] od0, od1;
  logic [2:0]  om0, om1;
  logic [1:0]  oc0, oc1;
  logic [1:0]  cnt0, cnt1;
  logic        emp0, emp1, ful0, ful1, ovf0, ovf1, dn0, dn1;

  int n_cmp = 0;
  int n_err = 0;

  operand_collector #(.WIDTH(8), .DEPTH(3), .OVF_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .put_valid(put_valid), .put_data(put_data),
    .put_ready(rdy0), .flush(flush), .out_data(od0), .out_mask(om0),
    .out_count(oc0), .count(cnt0), .empty(emp0), .full(ful0),
    .overflow(ovf0), .done(dn0)
  );

  operand_collector #(.WIDTH(8), .DEPTH(3), .OVF_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .put_valid(put_valid), .put_data(put_data),
    .put_ready(rdy1), .flush(flush), .out_data(od1), .out_mask(om1),
    .out_count(oc1), .count(cnt1), .empty(emp1), .full(ful1),
    .overflow(ovf1), .done(dn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic f);
    put_valid = v;
    put_data  = d;
    flush     = f;
    @(posedge clk);
    #1;
    put_valid = 1'b0;
    put_data  = 8'h00;
    flush     = 1'b0;
  endtask

  initial begin
    reset = 1'b0; put_valid = 1'b0; put_data = 8'h00; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_count0", cnt0, 0);  chk("rst_empty0", emp0, 1);
    chk("rst_full0", ful0, 0);   chk("rst_ready0", rdy0, 1);
    chk("rst_ready1", rdy1, 1);  chk("rst_done0", dn0, 0);
    chk("rst_od0", od0, 0);      chk("rst_ovf0", ovf0, 0);

    // Basic fill and publish
    step(1, 8'hA1, 0);
    chk("cnt_after_1", cnt0, 1); chk("empty_after_1", emp0, 0);
    step(1, 8'hB2, 0);
    step(1, 8'hC3, 0);
    chk("full0", ful0, 1);       chk("cnt_full", cnt0, 3);
    chk("ready0_full", rdy0, 1); chk("ready1_full", rdy1, 0);
    step(0, 8'h00, 1);
    chk("pub_od0", od0, 24'hC3B2A1); chk("pub_om0", om0, 3'b111);
    chk("pub_oc0", oc0, 3);          chk("pub_done0", dn0, 1);
    chk("pub_cnt0", cnt0, 0);        chk("pub_empty0", emp0, 1);
    chk("pub_od1", od1, 24'hC3B2A1);
    step(0, 8'h00, 0);
    chk("done_clear", dn0, 0);       chk("od_held", od0, 24'hC3B2A1);
    step(1, 8'h99, 0);
    chk("od_unaffected_by_put", od0, 24'hC3B2A1);
    step(0, 8'h00, 1);
    chk("single_od", od0, 24'h000099); chk("single_om", om0, 3'b001);

    // Overflow behaviour in both modes
    step(1, 8'h01, 0); step(1, 8'h02, 0); step(1, 8'h03, 0);
    chk("ovf0_before", ovf0, 0);
    step(1, 8'h7F, 0);
    chk("ovf0_set", ovf0, 1);      chk("ovf1_set", ovf1, 1);
    chk("ovf0_cnt", cnt0, 3);      chk("ovf1_cnt", cnt1, 3);
    step(0, 8'h00, 1);
    chk("ovf0_od", od0, 24'h7F0201); chk("ovf1_od", od1, 24'h030201);
    chk("ovf0_clear", ovf0, 0);      chk("ovf1_clear", ovf1, 0);
    chk("ready1_after_flush", rdy1, 1);

    // Put coinciding with flush
    step(1, 8'h55, 0);
    step(1, 8'h66, 1);
    chk("pf_od", od0, 24'h006655); chk("pf_om", om0, 3'b011);
    chk("pf_oc", oc0, 2);          chk("pf_cnt", cnt0, 0);
    chk("pf_done", dn0, 1);

    // Flushes while empty, back to back
    step(0, 8'h00, 1);
    chk("ef1_od", od0, 0); chk("ef1_om", om0, 0);
    chk("ef1_oc", oc0, 0); chk("ef1_done", dn0, 1);
    step(0, 8'h00, 1);
    chk("ef2_od", od0, 0); chk("ef2_done", dn0, 1);
    chk("ef2_done1", dn1, 1);
    step(0, 8'h00, 0);
    chk("ef_done_end", dn0, 0);

    // Overflow event in the flush cycle itself
    step(1, 8'h01, 0); step(1, 8'h02, 0); step(1, 8'h03, 0);
    step(1, 8'hAA, 1);
    chk("of_od0", od0, 24'hAA0201); chk("of_od1", od1, 24'h030201);
    chk("of_ovf0", ovf0, 1);        chk("of_ovf1", ovf1, 1);
    chk("of_om1", om1, 3'b111);
    step(0, 8'h00, 1);
    chk("of_ovf0_next", ovf0, 0);   chk("of_ovf1_next", ovf1, 0);

    // Reset while a done pulse is pending
    step(1, 8'h44, 1);
    chk("pre_rst_done", dn0, 1);
    reset = 1'b0; #1;
    chk("rst_cancel_done", dn0, 0); chk("rst_cancel_od", od0, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Reset mid-fill
    step(1, 8'h11, 1);
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    chk("mid_cnt", cnt0, 2); chk("mid_od", od0, 24'h000011);
    reset = 1'b0; #1;
    chk("mid_rst_cnt", cnt0, 0);   chk("mid_rst_empty", emp0, 1);
    chk("mid_rst_ready", rdy0, 1); chk("mid_rst_done", dn0, 0);
    chk("mid_rst_od", od0, 0);     chk("mid_rst_om", om0, 0);
    chk("mid_rst_oc", oc0, 0);     chk("mid_rst_ovf", ovf0, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready1", rdy1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
